// File: rtl/display_scan_pkg.sv
// Shared digit geometry, scan FSM encoding and helpers for the display_scan block.
// Optional anti-ghost blanking is enabled with SCAN_GHOST_BLANK_EN.
package display_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int CODE_W     = 4;
  localparam int DISP_W     = NUM_DIGITS * CODE_W;

  localparam logic [NUM_DIGITS-1:0] DIG_N_RST = 4'b1110;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  function automatic logic [CODE_W-1:0] digit_code(input logic [DISP_W-1:0] v,
                                                   input logic [1:0]        i);
    return v[CODE_W*i +: CODE_W];
  endfunction

  // Counter must hold the larger of the two slot lengths.
  function automatic int cnt_width(input int a, input int b);
    return (a > b) ? $clog2(a) : $clog2(b);
  endfunction

endpackage

// File: rtl/display_scan_tick.sv
// Reloadable down-counter: tc is high while the count sits at zero, and that
// same edge reloads the count with reload_val. Synchronous active-high reset.
module display_scan_tick #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] reload_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (tc) begin
      cnt_d = reload_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner with frame-aligned double-buffered loads.
// SCAN_GHOST_BLANK_EN inserts an all-off blank slot between digits; code lines lead the enable.
module display_scan
  import display_scan_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DISP_W-1:0]     d,
  output logic                  s3,
  output logic                  s2,
  output logic                  s1,
  output logic                  s0,
  output logic [NUM_DIGITS-1:0] dig_n,
  output logic                  frame_done
);

  localparam int CW = cnt_width(PRESCALE, BLANK_CYCLES);
  localparam logic [CW-1:0] PS_RELOAD = CW'(PRESCALE - 1);
`ifdef SCAN_GHOST_BLANK_EN
  localparam logic [CW-1:0] BL_RELOAD = CW'(BLANK_CYCLES - 1);
`endif

  scan_state_e           state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DISP_W-1:0]     shadow_q, shadow_d;
  logic [DISP_W-1:0]     disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [CODE_W-1:0]     s_q, s_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

  logic          tc;
  logic          adv;
  logic          wrap;
  logic [CW-1:0] reload_val;

  // The reload value is the length of the slot about to start.
  display_scan_tick #(
    .W       (CW),
    .RST_VAL (PS_RELOAD)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .reload_val (reload_val),
    .tc         (tc)
  );

  always_comb begin
    state_d    = state_q;
    reload_val = PS_RELOAD;
    adv        = 1'b0;
    case (state_q)
      SHOW: begin
`ifdef SCAN_GHOST_BLANK_EN
        reload_val = BL_RELOAD;
        if (tc) begin
          state_d = BLANK;
        end
`else
        adv = tc;
`endif
      end
      BLANK: begin
        adv = tc;
        if (tc) begin
          state_d = SHOW;
        end
      end
    endcase
  end

  assign wrap       = adv && (idx_q == 2'(NUM_DIGITS - 1));
  assign frame_done = wrap;

  always_comb begin
    idx_d     = idx_q + {1'b0, adv};
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;

    // A load landing on the boundary edge bypasses the shadow straight into disp.
    if (load) begin
      shadow_d = d;
      if (wrap) begin
        disp_d    = d;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    if (state_d == SHOW) begin
      s_d     = digit_code(disp_d, idx_d);
      dig_n_d = ~(NUM_DIGITS'(1) << idx_d);
    end else begin
      s_d     = digit_code(disp_d, idx_d + 2'd1);
      dig_n_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SHOW;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      s_q       <= '0;
      dig_n_q   <= DIG_N_RST;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      s_q       <= s_d;
      dig_n_q   <= dig_n_d;
    end
  end

  assign {s3, s2, s1, s0} = s_q;
  assign dig_n            = dig_n_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: time-based reference model plus directed frame vectors.
module tb_display_scan;

  localparam int PS = 4;
  localparam int BC = 2;
`ifdef SCAN_GHOST_BLANK_EN
  localparam int P = PS + BC;
`else
  localparam int P = PS;
`endif
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] d;
  logic        s3, s2, s1, s0;
  logic [3:0]  dig_n;
  logic        frame_done;

  display_scan #(.PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .d          (d),
    .s3         (s3),
    .s2         (s2),
    .s1         (s1),
    .s0         (s0),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: cycles since reset release, plus displayed/shadow values.
  int          t        = 0;
  logic [15:0] m_disp   = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend   = 1'b0;

  logic [3:0] obs_s;
  logic [3:0] obs_dn;
  logic       obs_fd;

  typedef struct {
    logic [15:0] d1;
    int          t1;
    logic [15:0] d2;
    int          t2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] rel_exp[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (model cycle %0d): got %h, expected %h", name, t, act, exp);
    end
  endtask

  function automatic bit m_boundary(input int tt);
    return ((tt + 1) % FRAME) == 0;
  endfunction

  // One clock: drive inputs, check outputs against the model mid-cycle, advance the model.
  task automatic cycle(input logic r, input logic l, input logic [15:0] dv);
    int         ph;
    int         dg;
    int         sel;
    bit         blank;
    bit         fd;
    logic [3:0] e_dn;
    logic [3:0] e_s;
    reset = r;
    load  = l;
    d     = dv;
    @(negedge clk);
    ph    = t % P;
    dg    = (t / P) % 4;
    blank = (ph >= PS);
    sel   = blank ? (dg + 1) % 4 : dg;
    e_dn  = blank ? 4'hF : ~(4'b0001 << dg);
    e_s   = m_disp[4*sel +: 4];
    fd    = m_boundary(t);
    obs_s  = {s3, s2, s1, s0};
    obs_dn = dig_n;
    obs_fd = frame_done;
    chk("model dig_n", obs_dn, e_dn);
    chk("model s", obs_s, e_s);
    chk("model frame_done", obs_fd, fd);
    @(posedge clk);
    #1;
    if (r) begin
      t        = 0;
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
    end else begin
      if (l) begin
        if (fd) begin
          m_disp = dv;
          m_pend = 1'b0;
        end else begin
          m_shadow = dv;
          m_pend   = 1'b1;
        end
      end else if (fd && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      t++;
    end
  endtask

  task automatic run_vec(input int vi);
    bit          l;
    logic [15:0] dv;
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    for (int tt = 0; tt < 2 * FRAME; tt++) begin
      l  = (tt == vecs[vi].t1) || (tt == vecs[vi].t2);
      dv = (tt == vecs[vi].t2) ? vecs[vi].d2 : vecs[vi].d1;
      cycle(1'b0, l, dv);
      if (tt >= FRAME && obs_dn != 4'hF) begin
        for (int i = 0; i < 4; i++) begin
          if (obs_dn == ~(4'b0001 << i)) begin
            chk($sformatf("vec%0d digit%0d code", vi, i), obs_s, vecs[vi].exp[4*i +: 4]);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_at;

    vecs[0] = '{d1: 16'h4321, t1: P + 1,     d2: 16'h0000, t2: -1,        exp: 16'h4321};
    vecs[1] = '{d1: 16'h1111, t1: 1,         d2: 16'hABCD, t2: 2 * P + 1, exp: 16'hABCD};
    vecs[2] = '{d1: 16'h9876, t1: FRAME - 1, d2: 16'h0000, t2: -1,        exp: 16'h9876};
    for (int i = 3; i < 6; i++) begin
      vecs[i].d1  = 16'($urandom);
      vecs[i].d2  = 16'($urandom);
      vecs[i].t1  = int'($urandom_range(0, FRAME - 2));
      vecs[i].t2  = int'($urandom_range(vecs[i].t1 + 1, FRAME - 1));
      vecs[i].exp = vecs[i].d2;
    end

`ifdef SCAN_GHOST_BLANK_EN
    rel_exp = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1101};
    r_at    = P + PS;
`else
    rel_exp = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101};
    r_at    = 2 * P - 1;
`endif

    // Reset held for three cycles, then the release sequence.
    reset = 1'b1;
    load  = 1'b0;
    d     = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'hFFFF);
    chk("reset s", obs_s, 4'b0000);
    chk("reset dig_n", obs_dn, 4'b1110);
    chk("reset frame_done", obs_fd, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      chk($sformatf("release dig_n[%0d]", i), obs_dn, rel_exp[i]);
    end

    for (int vi = 0; vi < 6; vi++) run_vec(vi);

    // Reset just before digit 2 with a load pending: the load must never surface.
    cycle(1'b1, 1'b0, 16'h0);
    for (int tt = 0; tt < r_at; tt++) begin
      cycle(1'b0, tt == P + 1, 16'h4321);
    end
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    chk("post-reset dig_n", obs_dn, 4'b1110);
    chk("post-reset s", obs_s, 4'b0000);
    for (int tt = 0; tt < 2 * FRAME; tt++) begin
      cycle(1'b0, 1'b0, 16'h0);
      chk("discarded load s", obs_s, 4'b0000);
    end

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Multiplexed display scanner sitting directly upstream of the per-segment decoders. Holds four 4-bit digit codes, time-multiplexes them onto the shared code lines s3..s0 and drives one active-low digit enable per digit. Each segment decoder consumes s3..s0 combinationally. Loads are double-buffered and applied only at frame boundaries, so a digit never shows a half-updated value.

## Interface
- PRESCALE, 50000: clocks per digit SHOW slot; legal range ≥ 2.
- BLANK_CYCLES, 16: clocks per inter-digit blank slot; legal range ≥ 1; ignored without the macro.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures d into the shadow register.
- d  in  16  digit codes; digit i = d[4i+3:4i].
- s3, s2, s1, s0  out  1 each  code of the currently selected digit, s3 = MSB.
- dig_n  out  4  active-low digit enables; bit i enables digit i.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- State: shadow[15:0], disp[15:0], pending, idx[1:0], cnt (prescaler), FSM {SHOW, BLANK}.
- Reset values: shadow=0, disp=0, pending=0, idx=0, cnt=0, state=SHOW.
- Reset output values: s=0000, dig_n=1110, frame_done=0.
- Outputs are a Moore decode of registered state, with no extra pipeline stage.
- SHOW:
  - dig_n = ~(1<<idx); s = disp[4·idx+3:4·idx].
  - cnt increments each clock; when cnt = PRESCALE−1, cnt clears and the FSM leaves SHOW.
- Leaving SHOW, macro defined: go to BLANK.
- Leaving SHOW, macro undefined: stay in SHOW and advance idx directly.
- BLANK:
  - dig_n = 1111.
  - s already presents the code of digit idx+1 (mod 4), so the code lines settle before the enable asserts.
  - cnt counts 0..BLANK_CYCLES−1, then clears; FSM returns to SHOW and idx advances.
- idx wraps 3→0; this advance is the frame boundary.
  - frame_done = 1 for that single cycle.
  - If pending: disp ← shadow and pending ← 0 on the same edge.
- load:
  - shadow ← d and pending ← 1.
  - Several loads in one frame: last wins.
  - load on the boundary cycle itself: d is written straight into disp on that edge (bypass) and pending stays 0.
- load while reset is high: ignored.
- Reset mid-operation (any state, any idx): all registers return to reset values on the next edge and the pending load is discarded.

## Timing
- Digit period: PRESCALE + BLANK_CYCLES clocks with the macro; PRESCALE clocks without.
- Frame period: 4 × digit period.
- Load-to-visible latency: from the load edge to the next frame boundary, at most one frame.
- dig_n and s change on the same edge; s leads dig_n assertion by BLANK_CYCLES when blanking is enabled.
- No enable is ever asserted on two digits at once.

## Configuration
- SCAN_GHOST_BLANK_EN defined: BLANK state and BLANK_CYCLES counter are compiled in, and all enables are deasserted between digits (anti-ghosting).
- SCAN_GHOST_BLANK_EN undefined: the FSM degenerates to SHOW only, and dig_n is never 1111 after reset.

## Structure
- Shared package/include holds:
  - NUM_DIGITS = 4, CODE_W = 4.
  - FSM state encodings SHOW = 1'b0, BLANK = 1'b1.
  - Reset value of dig_n (4'b1110).
- Natural sub-module: scan_tick.
  - Parameterised down-counter with synchronous reset and terminal-count pulse.
  - Instantiated once; its load value is reselected for PRESCALE or BLANK_CYCLES per state.

## Test plan (PRESCALE=4, BLANK_CYCLES=2 unless noted)
- Reset: hold reset 3 cycles → s=0000, dig_n=1110, frame_done=0. After release (macro on) → dig_n=1110 for 4 clocks, 1111 for 2, then 1101.
- Mid-frame load: load d=16'h4321 during digit 1 → outputs show 0000 until frame_done. Then digit0 s=0001, digit1 0010, digit2 0011, digit3 0100.
- Double load: 16'h1111 then 16'hABCD within one frame → next frame shows D, C, B, A on digits 0..3; 1 never appears.
- Boundary load: load 16'h9876 on the frame_done cycle → digit0 shows 0110 in that same SHOW slot.
- Reset during BLANK before digit 2, with pending=1 → next cycle dig_n=1110, s=0000; the pending value is never displayed.
- Macro undefined: dig_n sequence is 1110, 1101, 1011, 0111, 4 clocks each; never 1111; frame_done every 16 clocks.
